// File: rtl/result_drain.sv
// -----------------------------------------------------------------------------
// result_drain
//
// Receiving end of the batch filter's result stream. Every (dataIn, validIn)
// beat is captured into a circular buffer. The buffered words are then served
// to a downstream consumer over a valid/ready handshake. The producer cannot
// be stalled. When the buffer is full, an incoming beat is dropped, counted in
// a saturating counter, and flagged with a sticky overflow bit.
//
// Parameters
//   d_width   : result word width
//   depth     : buffer entries (power of two, >= 2)
//   cnt_width : width of the drop counter
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   rst       : synchronous active-high reset
//   dataIn    : result word from the filter
//   validIn   : dataIn is valid this cycle (no ready back to the producer)
//   dataOut   : head-of-buffer word (don't-care while validOut = 0)
//   validOut  : dataOut holds a valid word
//   readyOut  : consumer accepts dataOut this cycle
//   fill      : number of words currently stored
//   overflow  : sticky flag, set once any beat has been dropped
//   dropCount : saturating count of dropped beats
//   clrOvf    : clears overflow and dropCount, wins over a same-cycle drop
// -----------------------------------------------------------------------------
module result_drain #(
    parameter int d_width   = 32,
    parameter int depth     = 16,
    parameter int cnt_width = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [d_width-1:0]       dataIn,
    input  logic                     validIn,
    output logic [d_width-1:0]       dataOut,
    output logic                     validOut,
    input  logic                     readyOut,
    output logic [$clog2(depth):0]   fill,
    output logic                     overflow,
    output logic [cnt_width-1:0]     dropCount,
    input  logic                     clrOvf
);

    localparam int                ptrWidth  = $clog2(depth);
    localparam logic [ptrWidth:0] fullLevel = (ptrWidth + 1)'(depth);

    logic [d_width-1:0]  mem [depth];
    logic [ptrWidth-1:0] wrPtr;
    logic [ptrWidth-1:0] rdPtr;
    logic [ptrWidth:0]   fillCount;
    logic [ptrWidth:0]   fillNext;
    logic                isFull;
    logic                push;
    logic                pop;
    logic                drop;

    assign isFull   = (fillCount == fullLevel);
    assign validOut = (fillCount != '0);
    assign pop      = validOut && readyOut;
    // A full buffer still accepts a beat when the head leaves in the same
    // cycle, so a FULL buffer with simultaneous push and pop loses nothing.
    assign push     = validIn && (!isFull || pop);
    assign drop     = validIn && isFull && !pop;

    // No bypass path: the head is always read from registered storage.
    assign dataOut  = mem[rdPtr];
    assign fill     = fillCount;

    always_comb begin
        // NOTE: assign a default before any branch so that every path drives
        // fillNext; a missing path would infer a latch.
        fillNext = fillCount;
        unique case ({push, pop})
            2'b10:   fillNext = fillCount + (ptrWidth + 1)'(1);
            2'b01:   fillNext = fillCount - (ptrWidth + 1)'(1);
            default: fillNext = fillCount;
        endcase
    end

    // Pointers and occupancy. Pointers are exactly log2(depth) bits wide, so
    // they wrap modulo depth without any compare.
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every
        // always_ff block samples the pre-edge values of the others.
        if (rst) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fillCount <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + ptrWidth'(1);
            if (pop)  rdPtr <= rdPtr + ptrWidth'(1);
            fillCount <= fillNext;
        end
    end

    // NOTE: the storage array has no reset; valid/fill tracking alone decides
    // what is meaningful, so clearing the data would only cost logic.
    // Beats that arrive while rst is high are ignored.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wrPtr] <= dataIn;
        end
    end

    // Overflow bookkeeping. clrOvf wins over a drop in the same cycle, so that
    // drop is neither flagged nor counted.
    always_ff @(posedge clk) begin
        if (rst || clrOvf) begin
            overflow  <= 1'b0;
            dropCount <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (dropCount != '1) begin
                dropCount <= dropCount + cnt_width'(1);
            end
        end
    end

endmodule

// File: tb/tb_result_drain.sv
// -----------------------------------------------------------------------------
// tb_result_drain
//
// Self-checking bench for result_drain (depth 16, 4-bit drop counter).
// A queue-based reference model follows the stimulus: accepted beats are
// appended to an expected-word queue and drops are tallied. A separate monitor
// on the falling edge compares fill/validOut/overflow/dropCount against the
// model and pops and compares the head word whenever a transfer takes place.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_result_drain;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int CW    = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   dataIn;
    logic            validIn;
    logic [DW-1:0]   dataOut;
    logic            validOut;
    logic            readyOut;
    logic [4:0]      fill;
    logic            overflow;
    logic [CW-1:0]   dropCount;
    logic            clrOvf;

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference model state.
    logic [DW-1:0] expQ[$];
    int            mDrops = 0;
    bit            mOvf   = 1'b0;

    result_drain #(.d_width(DW), .depth(DEPTH), .cnt_width(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .dataIn   (dataIn),
        .validIn  (validIn),
        .dataOut  (dataOut),
        .validOut (validOut),
        .readyOut (readyOut),
        .fill     (fill),
        .overflow (overflow),
        .dropCount(dropCount),
        .clrOvf   (clrOvf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: acts on the inputs seen at each rising edge. The monitor
    // has already removed a word leaving in this cycle, so "full" here means a
    // full buffer with no simultaneous pop.
    always @(posedge clk) begin
        if (rst) begin
            expQ.delete();
            mDrops = 0;
            mOvf   = 1'b0;
        end else begin
            bit dropNow;
            dropNow = validIn && (expQ.size() >= DEPTH);
            if (validIn && !dropNow) expQ.push_back(dataIn);
            if (clrOvf) begin
                mDrops = 0;
                mOvf   = 1'b0;
            end else if (dropNow) begin
                mOvf = 1'b1;
                if (mDrops < (1 << CW) - 1) mDrops++;
            end
        end
    end

    // Monitor: inputs are stable mid-cycle, outputs settled since the last edge.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check("fill",      64'(fill),      64'(expQ.size()));
            check("validOut",  64'(validOut),  64'(expQ.size() != 0));
            check("overflow",  64'(overflow),  64'(mOvf));
            check("dropCount", 64'(dropCount), 64'(mDrops));
            if (expQ.size() != 0 && readyOut) begin
                logic [DW-1:0] want;
                want = expQ.pop_front();
                check("dataOut", 64'(dataOut), 64'(want));
            end
        end
    end

    // Drive one cycle of inputs; returns just after the consuming edge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic c);
        validIn  = v;
        dataIn   = d;
        readyOut = r;
        clrOvf   = c;
        @(posedge clk);
        #1;
    endtask

    // Settle point for directed checks; still ahead of the monitor edge.
    task automatic peek();
        #2;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        step(1'b1, 32'h1234, 1'b1, 1'b0);
        step(1'b1, 32'h5678, 1'b1, 1'b0);
        rst = 1'b0;
        step(1'b0, '0, 1'b0, 1'b0);
        peek();
        check("reset_fill",      64'(fill),      64'd0);
        check("reset_validOut",  64'(validOut),  64'd0);
        check("reset_overflow",  64'(overflow),  64'd0);
        check("reset_dropCount", 64'(dropCount), 64'd0);

        // Order and latency: continuous stream with the consumer always ready.
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, DW'(i), 1'b1, 1'b0);
            peek();
            check("stream_valid", 64'(validOut), 64'd1);
            check("stream_head",  64'(dataOut),  64'(i));
            check("stream_fill_le1", 64'(fill <= 5'd1), 64'd1);
        end
        drain();
        peek();
        check("stream_overflow", 64'(overflow), 64'd0);

        // Fill to full, then one dropped beat.
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(32'hA0 + i), 1'b0, 1'b0);
        peek();
        check("full_fill", 64'(fill), 64'd16);
        step(1'b1, 32'hB0, 1'b0, 1'b0);
        peek();
        check("drop_overflow",  64'(overflow),  64'd1);
        check("drop_count",     64'(dropCount), 64'd1);
        check("drop_fill",      64'(fill),      64'd16);
        check("drop_head",      64'(dataOut),   64'hA0);

        // Full with simultaneous push and pop: no loss, no new drop.
        step(1'b1, 32'hC0, 1'b1, 1'b0);
        peek();
        check("fullpp_fill",  64'(fill),      64'd16);
        check("fullpp_count", 64'(dropCount), 64'd1);
        check("fullpp_head",  64'(dataOut),   64'hA1);
        // 0xC0 should be the 16th word after this point (A1..AF, C0).
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            if (i == DEPTH - 2) begin
                peek();
                check("fullpp_c0_last", 64'(dataOut), 64'hC0);
            end
        end
        peek();
        check("fullpp_empty", 64'(validOut), 64'd0);

        // Wrap-around: push 10, pop 10, then fill completely.
        for (int i = 0; i < 10; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(32'hD00 + i), 1'b0, 1'b0);
        peek();
        check("wrap_fill", 64'(fill),    64'd16);
        check("wrap_head", 64'(dataOut), 64'hD00);
        drain();

        // Saturation of the 4-bit counter, then clear on a dropping cycle.
        for (int i = 0; i < DEPTH; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        peek();
        check("sat_count",    64'(dropCount), 64'd15);
        check("sat_overflow", 64'(overflow),  64'd1);
        step(1'b1, $urandom, 1'b0, 1'b1);
        peek();
        check("clr_overflow", 64'(overflow),  64'd0);
        check("clr_count",    64'(dropCount), 64'd0);
        check("clr_fill",     64'(fill),      64'd16);
        drain();

        // Reset mid-operation with a beat present.
        for (int i = 0; i < 7; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        peek();
        check("rstmid_fill_before", 64'(fill), 64'd7);
        rst = 1'b1;
        step(1'b1, 32'h99, 1'b0, 1'b0);
        rst = 1'b0;
        peek();
        check("rstmid_fill",     64'(fill),      64'd0);
        check("rstmid_validOut", 64'(validOut),  64'd0);
        check("rstmid_count",    64'(dropCount), 64'd0);
        step(1'b1, 32'h55, 1'b0, 1'b0);
        peek();
        check("rstmid_push_valid", 64'(validOut), 64'd1);
        check("rstmid_push_data",  64'(dataOut),  64'h55);
        drain();

        // Randomized traffic with occasional clears.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom,
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 40) == 0));
        end
        drain();
        peek();
        check("final_empty", 64'(validOut), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/result_drain.md
# result_drain

Receiving end of the batch filter's result stream. It captures every `(result, valid)` beat the filter emits on its single-cycle-valid output into a circular buffer. It then re-serves the beats to a downstream consumer (result RAM writer, file logger, or bus bridge) over a valid/ready handshake. Producer back-pressure does not exist, so overflow is detected, counted, and flagged instead of stalling the filter.

## Interface
Parameters:
- `d_width`, default 32: result word width. Set equal to the filter's `OUT_WIDTH`.
- `depth`, default 16: buffer entries. Must be a power of two and ≥2.
- `cnt_width`, default 16: width of the drop counter.

Ports:
- `clk`, input, 1: single clock. All state updates on its rising edge.
- `rst`, input, 1: reset. Synchronous, active-high.
- `dataIn`, input, `d_width`: result word from the filter.
- `validIn`, input, 1: `dataIn` is a valid result this cycle. There is no ready back to the producer.
- `dataOut`, output, `d_width`: head-of-buffer word.
- `validOut`, output, 1: `dataOut` holds a valid word.
- `readyOut`, input, 1: consumer accepts `dataOut` this cycle.
- `fill`, output, `$clog2(depth)+1`: number of words currently stored.
- `overflow`, output, 1: sticky flag. Set when at least one beat has been dropped.
- `dropCount`, output, `cnt_width`: saturating count of dropped beats.
- `clrOvf`, input, 1: clears `overflow` and `dropCount`. Buffer contents are untouched.

## Operation
- Storage is a register array `mem[depth]`, with write pointer `wrPtr` and read pointer `rdPtr`, each `$clog2(depth)` bits. Pointers wrap modulo `depth` naturally.
- `push = validIn && (fill != depth || pop)`.
- `pop = validOut && readyOut`.
- On push: `mem[wrPtr] <= dataIn`, `wrPtr <= wrPtr+1`.
- On pop: `rdPtr <= rdPtr+1`.
- `fill` update:
  - push only: `fill+1`.
  - pop only: `fill-1`.
  - both: unchanged.
- Drop condition is `validIn && fill==depth && !pop`. On a drop:
  - the word is discarded and `mem` is unchanged;
  - `overflow <= 1`;
  - `dropCount <= dropCount+1`, saturating at all-ones.
- `clrOvf` takes priority over a drop in the same cycle. Both `overflow` and `dropCount` go to 0 and that cycle's drop is not counted.
- `validOut = (fill != 0)`. `dataOut = mem[rdPtr]`, read combinationally from registered storage.
- `dataOut` is don't-care while `validOut=0`. `readyOut` is ignored while `validOut=0`.
- There is no bypass. A word pushed into an empty buffer is not presented in the same cycle.
- Conceptual state: EMPTY (`fill=0`), PARTIAL, FULL (`fill=depth`). Transitions follow the `fill` rules above.
  - FULL with simultaneous pop and push stays FULL with zero loss.
- Reset mid-stream discards all stored words. Beats arriving while `rst=1` are ignored.

## Timing
- Reset values: `fill=0`, `validOut=0`, `overflow=0`, `dropCount=0`, `wrPtr=rdPtr=0`. `dataOut` equals `mem[0]`; `mem` is not reset.
- Latency: `validIn` at edge t gives `validOut=1` and `dataOut=dataIn` after edge t, i.e. one cycle.
- Throughput: one push and one pop per cycle, sustained indefinitely when `readyOut=1`.
- `dataOut` and `validOut` change only after an edge where a pop, a push into an empty buffer, or `rst` occurred.
- `overflow` and `dropCount` update on the edge of the dropping cycle.
- The first cycle after `rst` deasserts accepts a push.

## Test plan
- **Order and latency.** Reset, hold `readyOut=1`, stream 1000 beats `0,1,2,…` with `validIn=1`. Expect outputs in the same order, each one cycle after its input, `fill` ≤1, `overflow=0`.
- **Fill to full.** `readyOut=0`, push 16 words `0xA0…0xAF`. Expect `fill=16`. A 17th beat `0xB0` gives `overflow=1`, `dropCount=1`, `fill=16`. Then `readyOut=1` drains exactly `0xA0…0xAF`.
- **Full with simultaneous push/pop.** At `fill=16`, pulse `validIn=1` (`0xC0`) and `readyOut=1` together. Expect pop of the head, `0xC0` stored at the tail, `fill=16`, `dropCount` unchanged. `0xC0` emerges as the 16th subsequent word.
- **Wrap-around.** Push 10, pop 10, then push 16 with `readyOut=0`. Expect `fill=16`, all 16 words correct in order after draining. Pointers wrap with no loss.
- **Saturation and clear.** With `cnt_width=4`, fill the buffer and drive 20 extra beats. Expect `dropCount=15`. Assert `clrOvf` in the same cycle as a drop: `overflow=0`, `dropCount=0` next cycle.
- **Reset mid-operation.** At `fill=7`, assert `rst` for 1 cycle while `validIn=1`. Expect `fill=0`, `validOut=0`, no drop counted. A subsequent push of `0x55` appears with `validOut=1` one cycle later.
